// File: rtl/timer_ctrl_if.sv
// Register-write, control and status bundle for the interval timer controller.
// The master drives configuration and control; the slave (timer) returns status.
interface timer_ctrl_if #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
);
  localparam int unsigned DATA_W = (WIDTH > PRESCALE_W) ? WIDTH : PRESCALE_W;

  logic              wr_en_i;
  logic [1:0]        wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              start_i;
  logic              stop_i;
  logic              irq_ack_i;
  logic [WIDTH-1:0]  count_o;
  logic              busy_o;
  logic              done_o;
  logic              irq_o;

  modport master (
    output wr_en_i, wr_addr_i, wr_data_i, start_i, stop_i, irq_ack_i,
    input  count_o, busy_o, done_o, irq_o
  );

  modport slave (
    input  wr_en_i, wr_addr_i, wr_data_i, start_i, stop_i, irq_ack_i,
    output count_o, busy_o, done_o, irq_o
  );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable interval timer: prescaled up-counter with one-shot/periodic
// modes, a register write port and a sticky interrupt.
module timer_ctrl #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  timer_ctrl_if.slave  bus
);

  localparam int unsigned CTRL_W       = 2;
  localparam int unsigned PERIODIC_BIT = 0;
  localparam int unsigned IRQ_EN_BIT   = 1;

  localparam logic [1:0] ADDR_RELOAD   = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_CTRL     = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  irq_q,      irq_d;
  logic [WIDTH-1:0]      count_q,    count_d;
  logic [WIDTH-1:0]      reload_q,   reload_d;
  logic [PRESCALE_W-1:0] psc_q,      psc_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [CTRL_W-1:0]     ctrl_q,     ctrl_d;

  logic run_c;
  logic stop_c;
  logic start_c;
  logic adv_c;
  logic tick_c;
  logic term_c;
  logic cfg_wr_c;

  // Control decode: stop beats start; counting only advances on quiet RUN cycles.
  always_comb begin
    run_c    = (state_q == RUN);
    stop_c   = bus.stop_i & run_c;
    start_c  = bus.start_i & ~bus.stop_i;
    adv_c    = run_c & ~bus.stop_i & ~bus.start_i;
    tick_c   = adv_c & (psc_q == prescale_q);
    term_c   = tick_c & (count_q == reload_q);
    cfg_wr_c = bus.wr_en_i & ~run_c;
  end

  // Register file next-state: RELOAD/PRESCALE are frozen while running, CTRL never is.
  always_comb begin
    reload_d   = reload_q;
    prescale_d = prescale_q;
    ctrl_d     = ctrl_q;
    if (cfg_wr_c && (bus.wr_addr_i == ADDR_RELOAD)) begin
      reload_d = bus.wr_data_i[WIDTH-1:0];
    end
    if (cfg_wr_c && (bus.wr_addr_i == ADDR_PRESCALE)) begin
      prescale_d = bus.wr_data_i[PRESCALE_W-1:0];
    end
    if (bus.wr_en_i && (bus.wr_addr_i == ADDR_CTRL)) begin
      ctrl_d = bus.wr_data_i[CTRL_W-1:0];
    end
  end

  // Counter, prescaler and interrupt next-state.
  always_comb begin
    psc_d   = psc_q;
    count_d = count_q;
    irq_d   = irq_q;

    if (stop_c || start_c) begin
      psc_d = '0;
    end else if (adv_c) begin
      psc_d = tick_c ? '0 : psc_q + PRESCALE_W'(1);
    end

    if (start_c) begin
      count_d = '0;
    end else if (term_c) begin
      count_d = ctrl_q[PERIODIC_BIT] ? '0 : count_q;
    end else if (tick_c) begin
      count_d = count_q + WIDTH'(1);
    end

    // A new terminal event outranks a simultaneous acknowledge.
    if (term_c && ctrl_q[IRQ_EN_BIT]) begin
      irq_d = 1'b1;
    end else if (bus.irq_ack_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q    <= '0;
      psc_q      <= '0;
      reload_q   <= '1;
      prescale_q <= '0;
      ctrl_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      psc_q      <= psc_d;
      reload_q   <= reload_d;
      prescale_q <= prescale_d;
      ctrl_q     <= ctrl_d;
      irq_q      <= irq_d;
    end
  end

  // Sequencing FSM with registered busy/done.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= term_c;
      case (state_q)
        IDLE, DONE: begin
          if (start_c) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (stop_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (term_c && !ctrl_q[PERIODIC_BIT]) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count_o = count_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.irq_o   = irq_q;

endmodule
